// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access kinds, error-type codes and the software-visible
// error record layouts.
package rv_iopmp_pkg;

    localparam int SID_W = 8;

    localparam logic [2:0] ERR_READ   = 3'd1;
    localparam logic [2:0] ERR_WRITE  = 3'd2;
    localparam logic [2:0] ERR_EXEC   = 3'd3;
    localparam logic [2:0] ERR_NOHIT  = 3'd5;
    localparam logic [2:0] ERR_UNKSID = 3'd6;
    localparam logic [2:0] ERR_OTHER  = 3'd7;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } access_t;

    typedef struct packed {
        logic       v;
        logic [1:0] ttype;
        logic [2:0] etype;
    } err_reqinfo_t;

    typedef struct packed {
        logic [15:0]      eid;
        logic [SID_W-1:0] sid;
    } err_reqid_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } cap_state_e;

endpackage

// File: rtl/rv_iopmp_sat_counter.sv
// Saturating up-counter; clear wins over increment in the same cycle.
module rv_iopmp_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rv_iopmp_err_capture.sv
// Holds the first unacknowledged IOPMP error record, counts errors lost while
// it is pending, and drives a level interrupt gated by the enable bit.
module rv_iopmp_err_capture
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH  = SID_W,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  txn_valid_i,
    input  logic                  err_transaction_i,
    input  logic [2:0]            err_type_i,
    input  logic [15:0]           err_entry_index_i,
    input  logic [SID_WIDTH-1:0]  sid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  access_t               access_type_i,
    input  logic                  ie_i,
    input  logic                  err_clr_i,
    output err_reqinfo_t          reqinfo_o,
    output logic [ADDR_WIDTH-1:0] reqaddr_o,
    output err_reqid_t            reqid_o,
    output logic [CNT_WIDTH-1:0]  lost_cnt_o,
    output logic                  irq_o
);

    cap_state_e            state_q, state_d;
    logic                  capture;
    logic                  load_en;
    logic                  cnt_inc;
    logic                  cnt_clr;
    logic [1:0]            ttype_q;
    logic [2:0]            etype_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SID_WIDTH-1:0]  sid_q;
    logic [15:0]           eid_q;
    logic                  irq_q;

    assign capture = txn_valid_i & err_transaction_i;

    // A clear and a new error together in HELD acts as clear-then-load.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    load_en = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (err_clr_i) begin
                    cnt_clr = 1'b1;
                    if (capture) begin
                        load_en = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (capture) begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= (state_q == ST_HELD) & ie_i;
        end
    end

    // Record fields go stale after a clear; only v tells software they are live.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ttype_q <= '0;
            etype_q <= '0;
            addr_q  <= '0;
            sid_q   <= '0;
            eid_q   <= '0;
        end else if (load_en) begin
            ttype_q <= access_type_i[1:0];
            etype_q <= err_type_i;
            addr_q  <= addr_i;
            sid_q   <= sid_i;
            eid_q   <= err_entry_index_i;
        end
    end

    rv_iopmp_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_lost_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (lost_cnt_o)
    );

    assign reqinfo_o.v     = (state_q == ST_HELD);
    assign reqinfo_o.ttype = ttype_q;
    assign reqinfo_o.etype = etype_q;
    assign reqaddr_o       = addr_q;
    assign reqid_o.eid     = eid_q;
    assign reqid_o.sid     = sid_q;
    assign irq_o           = irq_q;

endmodule
